// File: rtl/hdb3_decoder.sv
// hdb3_decoder: HDB3 rail-pair to NRZ decoder with violation-based substitution removal and line-code error monitoring
module hdb3_decoder #(
    parameter logic INIT_POL  = 1'b0,
    parameter int   ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 bp,
    input  logic                 bn,
    output logic                 data_out,
    output logic                 valid,
    output logic                 code_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic [3:0] sr;
    logic [2:0] fill;
    logic       last_pol, has_v, last_v_pol;
    logic [1:0] zero_cnt;
    logic       mark, pol, ill, is_v, zero4, err;
    always_comb begin
        mark  = bp ^ bn;
        pol   = bp;
        ill   = bp & bn;
        is_v  = mark && (pol == last_pol);
        zero4 = !mark && (zero_cnt == 2'd3);
        err   = ill || (is_v && (sr[0] || sr[1])) || (is_v && has_v && (pol == last_v_pol)) || zero4;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            fill       <= '0;
            last_pol   <= INIT_POL;
            has_v      <= 1'b0;
            last_v_pol <= 1'b0;
            zero_cnt   <= '0;
            data_out   <= 1'b0;
            valid      <= 1'b0;
            code_err   <= 1'b0;
            err_cnt    <= '0;
        end else if (en) begin
            data_out <= sr[3];
            // a violation wipes the V and the B/0 slots ahead of it
            sr       <= is_v ? 4'b0000 : {sr[2:0], mark};
            fill     <= (fill == 3'd4) ? fill : fill + 3'd1;
            valid    <= (fill == 3'd4);
            last_pol <= mark ? pol : last_pol;
            if (is_v) begin
                has_v      <= 1'b1;
                last_v_pol <= pol;
            end
            zero_cnt <= (mark || zero4) ? 2'd0 : zero_cnt + 2'd1;
            code_err <= err;
            if (err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end else begin
            valid    <= 1'b0;
            code_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hdb3_decoder.sv
// tb_hdb3_decoder: directed self-checking bench for hdb3_decoder
module tb_hdb3_decoder;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, bp = 1'b0, bn = 1'b0;
    logic       data_out, valid, code_err;
    logic [7:0] err_cnt;
    int         checks = 0, failures = 0, ce = 0;
    logic       got[$];
    hdb3_decoder #(.INIT_POL(1'b0), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .bp(bp), .bn(bn),
        .data_out(data_out), .valid(valid), .code_err(code_err), .err_cnt(err_cnt)
    );
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic sym(input byte c);
        en = 1'b1;
        bp = (c == "+" || c == "X");
        bn = (c == "-" || c == "X");
        @(posedge clk); #1;
        if (valid) got.push_back(data_out);
        if (code_err) ce++;
    endtask
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) sym(s[i]);
    endtask
    task automatic gap(input int n, input logic d, input string tag);
        en = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk({tag, "_valid"}, valid, 0);
            chk({tag, "_hold"}, data_out, d);
        end
    endtask
    task automatic do_reset;
        rst = 1'b1; en = 1'b1; bp = 1'b1; bn = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        got.delete();
        ce = 0;
    endtask
    function automatic logic [63:0] packed_got();
        logic [63:0] v = '0;
        foreach (got[i]) v = {v[62:0], got[i]};
        return v;
    endfunction
    initial begin
        // reset held with en and bp active
        rst = 1'b1; en = 1'b1; bp = 1'b1; bn = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_data", data_out, 0);
            chk("rst_valid", valid, 0);
            chk("rst_err", code_err, 0);
            chk("rst_cnt", err_cnt, 0);
        end
        // 000V
        do_reset();
        send("+000");
        chk("v000_fill4", valid, 0);
        send("+-+-+-");
        chk("v000_len", got.size(), 6);
        chk("v000_bits", packed_got(), 64'b100001);
        chk("v000_ce", ce, 0);
        chk("v000_cnt", err_cnt, 0);
        // B00V
        do_reset();
        send("+-+00+-+-+-");
        chk("b00v_len", got.size(), 7);
        chk("b00v_bits", packed_got(), 64'b1100001);
        chk("b00v_ce", ce, 0);
        // full encoder sequence
        do_reset();
        send("+-+00+-000-+00+-+-00-+-+000+-+-+00-0+000-+-00-+00+-00-+-+000+-+0-+-+");
        chk("full_len", got.size(), 64);
        chk("full_bits", packed_got(), 64'b1100001000000001100001110000111100101000110000000000001110000110);
        chk("full_ce", ce, 0);
        chk("full_cnt", err_cnt, 0);
        // B00V with en gaps
        do_reset();
        send("+-+00+");
        gap(3, 1'b1, "gap1");
        send("-+");
        gap(3, 1'b0, "gap2");
        send("-+-");
        chk("gap_len", got.size(), 7);
        chk("gap_bits", packed_got(), 64'b1100001);
        chk("gap_ce", ce, 0);
        // line-code errors
        do_reset();
        sym("X");
        chk("ill_pulse", code_err, 1);
        chk("ill_cnt", err_cnt, 1);
        send("+000");
        chk("z3_quiet", code_err, 0);
        sym("0");
        chk("z4_pulse", code_err, 1);
        chk("z4_cnt", err_cnt, 2);
        sym("+");
        chk("v_legal", code_err, 0);
        sym("-");
        chk("mark_ok", code_err, 0);
        sym("-");
        chk("v_after_mark", code_err, 1);
        chk("v_after_mark_cnt", err_cnt, 3);
        repeat (251) sym("X");
        chk("sat_254", err_cnt, 254);
        sym("X");
        chk("sat_255", err_cnt, 255);
        repeat (8) sym("X");
        chk("sat_hold", err_cnt, 255);
        chk("sat_pulse", code_err, 1);
        // mid-stream reset
        send("+-+-+-");
        chk("mid_valid_pre", valid, 1);
        do_reset();
        chk("mid_rst_cnt", err_cnt, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_err", code_err, 0);
        for (int i = 0; i < 4; i++) begin
            sym((i % 2 == 0) ? "+" : "-");
            chk("mid_refill", valid, 0);
        end
        sym("+");
        chk("mid_valid_back", valid, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
